// File: rtl/res_wr_arbiter.sv
// Round-robin arbiter sharing one result-RAM write port among NUM_LANES lanes, with job sequencing.
// Optional per-lane accepted-beat counters are enabled by defining RES_WR_COUNT_EN.
module res_wr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          comp_enb,
    input  logic [NUM_LANES-1:0]          lane_valid,
    input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   lane_data,
    input  logic [NUM_LANES-1:0]          lane_done,
    output logic [NUM_LANES-1:0]          lane_ready,
    output logic [ADDR_W-1:0]             res_addr,
    output logic [DATA_W-1:0]             res_data,
    output logic                          res_web,
    output logic                          busyb,
    output logic                          done
`ifdef RES_WR_COUNT_EN
    ,
    output logic [NUM_LANES*16-1:0]       wr_count
`endif
);

    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           r_state;
    logic [PW-1:0]        r_ptr;
    logic [NUM_LANES-1:0] r_done_seen;
    logic [ADDR_W-1:0]    r_res_addr;
    logic [DATA_W-1:0]    r_res_data;
    logic                 r_res_web;
    logic                 r_busyb;
    logic                 r_done;

    logic [1:0]           w_state_nxt;
    logic [NUM_LANES-1:0] w_grant;
    logic                 w_found;
    logic [PW-1:0]        w_gidx;
    logic [PW-1:0]        w_cand;
    logic [PW-1:0]        w_ptr_nxt;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_done_all;
    logic                 w_pending;
    logic                 w_start;

    assign w_start    = (r_state == S_IDLE) && comp_enb;
    // Lanes that finish this very cycle count, so the last beat and its done pulse close the job together.
    assign w_done_all = &(r_done_seen | lane_done);
    assign w_pending  = |(lane_valid & ~w_grant);

    // Rotating priority search starting at the pointer; first valid lane wins.
    always_comb begin
        w_grant = {NUM_LANES{1'b0}};
        w_found = 1'b0;
        w_gidx  = {PW{1'b0}};
        w_cand  = {PW{1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NUM_LANES);
            if ((r_state == S_RUN) && !w_found && lane_valid[w_cand]) begin
                w_grant[w_cand] = 1'b1;
                w_found         = 1'b1;
                w_gidx          = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next pointer value: one past the granted lane, wrapping.
    always_comb begin
        if (w_gidx == PW'(NUM_LANES - 1)) begin
            w_ptr_nxt = {PW{1'b0}};
        end else begin
            w_ptr_nxt = w_gidx + PW'(1);
        end
    end

    // One-hot grant makes an AND-OR mux sufficient for the winning lane's beat.
    always_comb begin
        w_sel_addr = {ADDR_W{1'b0}};
        w_sel_data = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            w_sel_addr = w_sel_addr | (lane_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_grant[i]}});
            w_sel_data = w_sel_data | (lane_data[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
        end
    end

    // Job sequencer next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (comp_enb) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_done_all && !w_pending) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FIN: begin
                if (!w_found) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state, round-robin pointer, sticky done flags and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= {PW{1'b0}};
            r_done_seen <= {NUM_LANES{1'b0}};
            r_busyb     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busyb <= (w_state_nxt == S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_start) begin
                r_ptr <= {PW{1'b0}};
            end else if (w_found) begin
                r_ptr <= w_ptr_nxt;
            end else begin
                r_ptr <= r_ptr;
            end
            if (w_start) begin
                r_done_seen <= {NUM_LANES{1'b0}};
            end else if (r_state == S_RUN) begin
                r_done_seen <= r_done_seen | lane_done;
            end else begin
                r_done_seen <= r_done_seen;
            end
        end
    end

    // Single-entry output stage; reset drops any captured beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_web  <= 1'b1;
            r_res_addr <= {ADDR_W{1'b0}};
            r_res_data <= {DATA_W{1'b0}};
        end else begin
            r_res_web <= !w_found;
            if (w_found) begin
                r_res_addr <= w_sel_addr;
                r_res_data <= w_sel_data;
            end else begin
                r_res_addr <= r_res_addr;
                r_res_data <= r_res_data;
            end
        end
    end

`ifdef RES_WR_COUNT_EN
    logic [NUM_LANES*16-1:0] r_wr_count;

    // Per-lane accepted-beat counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_wr_count <= {(NUM_LANES*16){1'b0}};
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_grant[i]) begin
                    r_wr_count[i*16 +: 16] <= r_wr_count[i*16 +: 16] + 16'd1;
                end else begin
                    r_wr_count[i*16 +: 16] <= r_wr_count[i*16 +: 16];
                end
            end
        end
    end

    assign wr_count = r_wr_count;
`endif

    assign lane_ready = w_grant;
    assign res_addr   = r_res_addr;
    assign res_data   = r_res_data;
    assign res_web    = r_res_web;
    assign busyb      = r_busyb;
    assign done       = r_done;

endmodule
